// File: rtl/sp_pc_pkg.sv
// Shared definitions for the RSP instruction-memory PC sequencer.
package sp_pc_pkg;

    localparam int PC_AW = 10;
    localparam logic [PC_AW-1:0] SP_RESET_PC = '0;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        DSLOT = 2'd2
    } sp_state_t;

    // The unused encoding 2'd3 is treated as HALT so a corrupted state parks safely.
    function automatic sp_state_t decode_state(input logic [1:0] raw);
        case (raw)
            2'd1:    return RUN;
            2'd2:    return DSLOT;
            default: return HALT;
        endcase
    endfunction

endpackage

// File: rtl/sp_pc_seq_if.sv
// Control/feedback bundle between the sequencer, the core and the PC register.
//
// Handshake: there is no valid/ready pair. pc_en is the one qualifier. On every
// rising edge where pc_en=1 the PC register loads pc_next; pc_next is
// meaningful only while pc_en=1 or while reset is high. All other inputs are
// level signals sampled on the same edge.
interface sp_pc_seq_if
    import sp_pc_pkg::*;
#(
    parameter int AW = PC_AW
);
    logic          halt;
    logic          single_step;
    logic          stall;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic          pc_wr;
    logic [AW-1:0] pc_wr_data;
    logic [AW-1:0] pc_cur;
    logic [AW-1:0] pc_next;
    logic          pc_en;
    logic          in_dslot;
    logic          running;
    sp_state_t     state_dbg;

    modport master (
        output halt, single_step, stall, br_taken, br_target,
               pc_wr, pc_wr_data, pc_cur,
        input  pc_next, pc_en, in_dslot, running, state_dbg
    );

    modport slave (
        input  halt, single_step, stall, br_taken, br_target,
               pc_wr, pc_wr_data, pc_cur,
        output pc_next, pc_en, in_dslot, running, state_dbg
    );
endinterface

// File: rtl/sp_pc_inc.sv
// Wrapping word-address incrementer; the top word rolls over to zero silently.
module sp_pc_inc #(
    parameter int AW = 10
) (
    input  logic [AW-1:0] a,
    output logic [AW-1:0] y
);
    assign y = a + AW'(1);
endmodule

// File: rtl/sp_pc_seq.sv
// Next-address sequencer feeding the enabled PC register (in/en), with q fed back as pc_cur.
// Handles increment, taken branches with one delay slot, halt, single-step and host writes.
module sp_pc_seq
    import sp_pc_pkg::*;
#(
    parameter int            AW       = PC_AW,
    parameter logic [AW-1:0] RESET_PC = AW'(SP_RESET_PC)
) (
    input logic        clk,
    input logic        reset,
    sp_pc_seq_if.slave bus
);
    logic [1:0]    state_q;
    sp_state_t     cur;
    sp_state_t     state_d;
    logic [AW-1:0] tgt_q;
    logic [AW-1:0] tgt_d;
    logic          step_q;
    logic          step_d;
    // A delay slot reached by a single step waits for another step while halted.
    logic          park_q;
    logic          park_d;
    logic [AW-1:0] inc;
    logic          parked;
    logic          wr_ok;
    logic          step_ok;
    logic          adv;

    sp_pc_inc #(.AW(AW)) u_inc (
        .a (bus.pc_cur),
        .y (inc)
    );

    assign cur    = decode_state(state_q);
    assign parked = (cur == DSLOT) && park_q && bus.halt;

    // Host writes land only when the sequencer is stopped and no step is pending.
    assign wr_ok = bus.pc_wr && !step_q && ((cur == HALT) || parked);

    // A step pulse is taken only while halted; a same-cycle host write drops it.
    assign step_ok = bus.single_step && bus.halt && !bus.pc_wr &&
                     ((cur == HALT) || ((cur == DSLOT) && park_q));

    // Advance: running without halt, a pending delay slot, or a pending step; stall blocks all.
    always_comb begin
        adv = 1'b0;
        case (cur)
            RUN:     adv = !bus.halt && !bus.stall;
            DSLOT:   adv = !bus.stall && !(parked && !step_q);
            default: adv = step_q && !bus.stall;
        endcase
    end

    // State register: FSM state, latched branch target, step request and park flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HALT;
            tgt_q   <= '0;
            step_q  <= 1'b0;
            park_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            park_q  <= park_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = cur;
        tgt_d   = tgt_q;
        park_d  = park_q;
        step_d  = bus.halt && ((step_q && !adv) || step_ok);
        case (cur)
            RUN: begin
                if (bus.halt) begin
                    state_d = HALT;
                end else if (adv && bus.br_taken) begin
                    state_d = DSLOT;
                    tgt_d   = bus.br_target;
                    park_d  = 1'b0;
                end
            end
            DSLOT: begin
                if (wr_ok) begin
                    state_d = HALT;
                    tgt_d   = '0;
                    park_d  = 1'b0;
                end else if (adv) begin
                    state_d = bus.halt ? HALT : RUN;
                    park_d  = 1'b0;
                end
            end
            default: begin
                if (wr_ok) begin
                    tgt_d = '0;
                end else if (adv) begin
                    if (bus.br_taken) begin
                        state_d = DSLOT;
                        tgt_d   = bus.br_target;
                        park_d  = bus.halt;
                    end else begin
                        state_d = bus.halt ? HALT : RUN;
                    end
                end else if (!bus.halt) begin
                    state_d = RUN;
                end
            end
        endcase
    end

    // Output logic: zero-latency address/enable to the PC register plus status.
    always_comb begin
        bus.pc_en     = 1'b0;
        bus.pc_next   = inc;
        bus.in_dslot  = 1'b0;
        bus.running   = 1'b0;
        bus.state_dbg = cur;
        if (reset) begin
            bus.pc_next = RESET_PC;
        end else begin
            bus.in_dslot = (cur == DSLOT);
            bus.running  = (cur != HALT);
            if (wr_ok) begin
                bus.pc_en   = 1'b1;
                bus.pc_next = bus.pc_wr_data;
            end else if (adv) begin
                bus.pc_en   = 1'b1;
                bus.pc_next = (cur == DSLOT) ? tgt_q : inc;
            end
        end
    end

endmodule

// File: tb/tb_sp_pc_seq.sv
// Self-checking bench for sp_pc_seq: directed scenarios with literal expectations,
// then random stimulus checked every cycle against a flag-based behavioural model.
module tb_sp_pc_seq;
    import sp_pc_pkg::*;

    localparam int            AW       = 10;
    localparam logic [AW-1:0] RESET_PC = '0;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [AW-1:0] pc_q;
    logic [AW-1:0] exp_q[$];

    // Model: running flag, pending-branch flag, parked flag, step request, target, PC.
    logic          m_run, m_pend, m_park, m_step;
    logic [AW-1:0] m_tgt, m_pc;

    sp_pc_seq_if #(.AW(AW)) bus ();

    sp_pc_seq #(.AW(AW), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Clock and the PC register that closes the loop.
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else if (bus.pc_en) pc_q <= bus.pc_next;
    end
    assign bus.pc_cur = pc_q;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic h, input logic ss, input logic st, input logic br,
                          input logic [AW-1:0] bt, input logic wr, input logic [AW-1:0] wd);
        bus.halt        = h;
        bus.single_step = ss;
        bus.stall       = st;
        bus.br_taken    = br;
        bus.br_target   = bt;
        bus.pc_wr       = wr;
        bus.pc_wr_data  = wd;
    endtask

    // Literal expectation at the next falling edge.
    task automatic expect_pc(input string nm, input logic en, input logic [AW-1:0] nx);
        @(negedge clk);
        check({nm, "_en"}, 32'(bus.pc_en), 32'(en));
        if (en) check({nm, "_next"}, 32'(bus.pc_next), 32'(nx));
    endtask

    // Scoreboard: model expectations compared with the DUT every falling edge.
    always @(negedge clk) begin
        logic          e_en, consumed, eligible;
        logic          n_run, n_pend, n_park;
        logic [AW-1:0] e_next, n_tgt;
        if (rst) begin
            check("rst_en", 32'(bus.pc_en), 32'(0));
            check("rst_next", 32'(bus.pc_next), 32'(RESET_PC));
            check("rst_dslot", 32'(bus.in_dslot), 32'(0));
            check("rst_running", 32'(bus.running), 32'(0));
            m_run = 0; m_pend = 0; m_park = 0; m_step = 0;
            m_tgt = '0; m_pc = RESET_PC;
            exp_q.delete();
        end else begin
            e_en = 0; consumed = 0;
            e_next = m_pc + AW'(1);
            n_run = m_run; n_pend = m_pend; n_park = m_park; n_tgt = m_tgt;
            eligible = (!m_run && !m_pend) || (m_pend && m_park);
            check("dslot", 32'(bus.in_dslot), 32'(m_pend));
            check("running", 32'(bus.running), 32'(m_run || m_pend));
            check("state", 32'(bus.state_dbg), m_pend ? 32'd2 : (m_run ? 32'd1 : 32'd0));
            if (m_pend) begin
                if (bus.pc_wr && m_park && bus.halt && !m_step) begin
                    e_en = 1; e_next = bus.pc_wr_data;
                    n_pend = 0; n_run = 0; n_park = 0; n_tgt = '0;
                end else if (!bus.stall && !(m_park && bus.halt && !m_step)) begin
                    e_en = 1; e_next = m_tgt; consumed = m_step;
                    n_pend = 0; n_park = 0; n_run = !bus.halt;
                end
            end else if (m_run) begin
                if (bus.halt) begin
                    n_run = 0;
                end else if (!bus.stall) begin
                    e_en = 1;
                    if (bus.br_taken) begin
                        n_pend = 1; n_tgt = bus.br_target; n_park = 0;
                    end
                end
            end else begin
                if (bus.pc_wr && !m_step) begin
                    e_en = 1; e_next = bus.pc_wr_data; n_tgt = '0;
                end else if (m_step && !bus.stall) begin
                    e_en = 1; consumed = 1; n_run = !bus.halt;
                    if (bus.br_taken) begin
                        n_pend = 1; n_tgt = bus.br_target; n_park = bus.halt;
                    end
                end else if (!bus.halt) begin
                    n_run = 1;
                end
            end
            check("pc_en", 32'(bus.pc_en), 32'(e_en));
            if (e_en) exp_q.push_back(e_next);
            if (bus.pc_en) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pc_next_unexpected got %0h expected none at %0t", bus.pc_next, $time);
                end else begin
                    check("pc_next", 32'(bus.pc_next), 32'(exp_q.pop_front()));
                end
            end
            exp_q.delete();
            m_step = bus.halt && ((m_step && !consumed) || (bus.single_step && !bus.pc_wr && eligible));
            m_run = n_run; m_pend = n_pend; m_park = n_park; m_tgt = n_tgt;
            if (e_en) m_pc = e_next;
        end
    end

    // Driver: directed scenarios, a mid-cycle reset, then random traffic.
    initial begin
        rst = 1'b1;
        set_in(1, 0, 0, 0, '0, 0, '0);
        repeat (2) @(posedge clk);
        expect_pc("reset", 0, '0);
        check("reset_running", 32'(bus.running), 32'(0));
        @(posedge clk);
        #3;
        rst = 1'b0;
        set_in(0, 0, 0, 0, '0, 0, '0);
        expect_pc("wake", 0, '0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_pc("seq", 1, AW'(i));
        end
        tick(); set_in(1, 0, 0, 0, '0, 0, '0);       expect_pc("halt_run", 0, '0);
        tick(); set_in(1, 0, 0, 0, '0, 1, 10'd1023); expect_pc("wr_top", 1, 10'd1023);
        tick(); set_in(0, 0, 0, 0, '0, 0, '0);       expect_pc("wake2", 0, '0);
        tick();                                      expect_pc("wrap", 1, 10'd0);
        tick(); set_in(1, 0, 0, 0, '0, 0, '0);       expect_pc("halt2", 0, '0);
        tick(); set_in(1, 0, 0, 0, '0, 1, 10'h010);  expect_pc("wr_010", 1, 10'h010);
        tick(); set_in(0, 0, 0, 0, '0, 0, '0);       expect_pc("wake3", 0, '0);
        tick(); set_in(0, 0, 0, 1, 10'h200, 0, '0);  expect_pc("br_seq", 1, 10'h011);
        tick(); set_in(0, 0, 0, 0, '0, 0, '0);       expect_pc("br_jump", 1, 10'h200);
        check("br_dslot", 32'(bus.in_dslot), 32'(1));
        tick();                                      expect_pc("br_after", 1, 10'h201);
        check("br_after_dslot", 32'(bus.in_dslot), 32'(0));
        tick(); set_in(0, 0, 0, 1, 10'h300, 0, '0);  expect_pc("br2_seq", 1, 10'h202);
        for (int i = 0; i < 3; i++) begin
            tick(); set_in(1, 0, 1, 0, '0, 0, '0);   expect_pc("dslot_stall", 0, '0);
            check("dslot_stall_flag", 32'(bus.in_dslot), 32'(1));
        end
        tick(); set_in(1, 0, 0, 0, '0, 0, '0);       expect_pc("dslot_halt_jump", 1, 10'h300);
        tick();                                      expect_pc("halted", 0, '0);
        check("halted_running", 32'(bus.running), 32'(0));
        tick(); set_in(1, 0, 0, 0, '0, 1, 10'h155);  expect_pc("wr_155", 1, 10'h155);
        tick(); set_in(1, 1, 0, 0, '0, 0, '0);       expect_pc("step_req", 0, '0);
        tick(); set_in(1, 0, 0, 0, '0, 0, '0);       expect_pc("step_adv", 1, 10'h156);
        tick();                                      expect_pc("step_done", 0, '0);
        tick(); set_in(1, 1, 0, 0, '0, 0, '0);       expect_pc("step2_req", 0, '0);
        tick(); set_in(1, 0, 0, 1, 10'h3F0, 0, '0);  expect_pc("step_br", 1, 10'h157);
        tick(); set_in(1, 0, 0, 0, '0, 0, '0);       expect_pc("parked", 0, '0);
        check("parked_dslot", 32'(bus.in_dslot), 32'(1));
        tick(); set_in(1, 1, 0, 0, '0, 0, '0);       expect_pc("step3_req", 0, '0);
        tick(); set_in(1, 0, 0, 0, '0, 0, '0);       expect_pc("step_dslot", 1, 10'h3F0);
        tick();                                      expect_pc("step_dslot_done", 0, '0);
        tick(); set_in(1, 1, 0, 0, '0, 0, '0);       expect_pc("step4_req", 0, '0);
        tick(); set_in(1, 0, 0, 1, 10'h111, 0, '0);  expect_pc("step_br2", 1, 10'h3F1);
        tick(); set_in(1, 0, 0, 0, '0, 1, 10'h222);  expect_pc("wr_discard", 1, 10'h222);
        tick(); set_in(1, 0, 0, 0, '0, 0, '0);       expect_pc("discarded", 0, '0);
        check("discarded_dslot", 32'(bus.in_dslot), 32'(0));
        tick(); set_in(0, 0, 0, 0, '0, 0, '0);       expect_pc("wake4", 0, '0);
        tick(); set_in(0, 0, 0, 1, 10'h0AB, 0, '0);  expect_pc("br3_seq", 1, 10'h223);
        tick(); set_in(0, 0, 1, 0, '0, 0, '0);       expect_pc("br3_stall", 0, '0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_en", 32'(bus.pc_en), 32'(0));
        check("async_rst_next", 32'(bus.pc_next), 32'(RESET_PC));
        check("async_rst_dslot", 32'(bus.in_dslot), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        set_in(1, 0, 0, 0, '0, 0, '0);
        expect_pc("post_rst", 0, '0);
        check("post_rst_state", 32'(bus.state_dbg), 32'(HALT));

        for (int i = 0; i < 3000; i++) begin
            tick();
            bus.halt        = ($urandom_range(0, 19) == 0) ? !bus.halt : bus.halt;
            bus.stall       = ($urandom_range(0, 3) == 0);
            bus.br_taken    = ($urandom_range(0, 4) == 0);
            bus.br_target   = AW'($urandom_range(0, 1023));
            bus.single_step = ($urandom_range(0, 7) == 0);
            bus.pc_wr       = ($urandom_range(0, 9) == 0);
            bus.pc_wr_data  = AW'($urandom_range(0, 1023));
        end
        tick();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sp_pc_seq.md
Name: sp_pc_seq

Overview:
- Next-address sequencer for the RSP instruction-memory program counter.
- Sits directly upstream of the 10-bit enabled PC register (spasdffen_10_0_h) and drives that register's in and en pins.
- Reads the register's q output back as pc_cur.
- Handles sequential increment, taken branches with one delay slot, halt, single-step and host PC writes while halted.

Parameters:
- AW, 10, PC width in IMEM words (1024 words = 4 KB).
- RESET_PC, 0, value presented on pc_next while reset is high.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- halt  input  1  SP halt status; 1 = sequencer stops advancing.
- single_step  input  1  one-cycle pulse; honoured only in HALT with halt=1.
- stall  input  1  pipeline stall; 1 = no advance this cycle.
- br_taken  input  1  instruction at pc_cur is a taken branch/jump; qualified by an advance.
- br_target  input  AW  branch target word address.
- pc_wr  input  1  host write to the SP_PC register.
- pc_wr_data  input  AW  host write data.
- pc_cur  input  AW  current PC, fed back from the PC register q.
- pc_next  output  AW  to PC register in.
- pc_en  output  1  to PC register en; register loads pc_next on this edge.
- in_dslot  output  1  the current instruction is a branch delay slot.
- running  output  1  state is not HALT.

Behaviour:
- State register: HALT, RUN, DSLOT. Also holds tgt_q[AW-1:0] and a step_q flag.
- Reset (asynchronous): state=HALT, tgt_q=0, step_q=0.
- Outputs while reset is high: pc_en=0, pc_next=RESET_PC, in_dslot=0, running=0.
- pc_next and pc_en are combinational from state and inputs. Zero latency: the PC register captures on the same edge.
- Advance condition (adv): (state==RUN or state==DSLOT or step_q) and !stall.
- Sequential address: pc_cur+1 modulo 2^AW, so 1023 wraps to 0 with no flag.
- In RUN, when adv:
  - pc_next = pc_cur+1, pc_en=1.
  - If br_taken: tgt_q<=br_target, go to DSLOT.
  - br_taken with adv=0 (stall) is ignored; the branch unit holds it until the stall clears.
- In DSLOT, when adv:
  - pc_next = tgt_q, pc_en=1, return to RUN.
  - br_taken in DSLOT (branch in delay slot) is ignored.
  - in_dslot=1 throughout DSLOT.
- Halt handling:
  - halt=1 in RUN: go to HALT at the next edge. pc_en=0 that cycle, so no advance.
  - halt=1 in DSLOT: deferred. The delay-slot advance to tgt_q completes first (when !stall), then HALT. The pending target is never lost.
  - halt=0 in HALT: go to RUN next edge. No advance in that cycle.
- Single step:
  - single_step with halt=1 in HALT sets step_q.
  - Next cycle with !stall: one advance, then step_q clears. step_q stays set through stall cycles.
  - If the stepped instruction has br_taken: tgt_q latched, state=DSLOT with halt still 1, so the next step performs the delay-slot jump.
- Host PC write:
  - pc_wr in HALT with step_q=0: pc_next=pc_wr_data, pc_en=1 the same cycle, and tgt_q is cleared.
  - If the host writes while a branch is pending (state DSLOT under halt), the pending branch is discarded: state forced to HALT.
  - pc_wr while running is ignored.
- Simultaneous events:
  - pc_wr beats single_step in the same cycle; the step pulse is dropped.
  - stall beats everything except pc_wr and reset.
- Reset mid-branch: the pending target is discarded and the state returns to HALT.

Decomposition:
- Shared package sp_pc_pkg:
  - state encoding typedef: HALT=2'd0, RUN=2'd1, DSLOT=2'd2 (2'd3 illegal, decodes to HALT).
  - PC_AW=10.
  - SP_RESET_PC constant.
- Sub-module sp_pc_inc: AW-bit wrapping incrementer, combinational, reused by the DMEM address path.

Test Plan:
- Reset, halt=0, pc_cur=0 -> next cycle RUN; subsequent cycles pc_en=1 and pc_next=1,2,3 (testbench loops pc_next into pc_cur through the register).
- pc_cur=1023 with adv -> pc_next=0, pc_en=1.
- RUN, pc_cur=0x010, br_taken=1, br_target=0x200 -> pc_next=0x011 with in_dslot=1 next cycle; then pc_next=0x200 and state returns to RUN.
- DSLOT with stall=1 for 3 cycles, then halt=1 -> pc_en=0 for 3 cycles; then one advance to tgt_q, then HALT with running=0.
- HALT, pc_wr=1 with pc_wr_data=0x155 -> pc_next=0x155, pc_en=1 that cycle; then single_step -> exactly one advance to 0x156, then pc_en=0.
- Assert reset asynchronously in DSLOT (mid-cycle, not at an edge) -> pc_en=0 and pc_next=RESET_PC immediately; after release state=HALT and tgt_q=0.
